// File: rtl/free_list.sv
// Physical-register free list for a 3-wide rename stage: circular FIFO of free tags
// with an architectural head used to rewind speculative allocation on mispredict.
module free_list #(
    parameter int FL_SIZE   = 32,
    parameter int FL_IDX    = 5,
    parameter int PR        = 6,
    parameter int ARCH_REGS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 BPRecoverEN,
    input  logic [2:0]           dispatch_req,
    input  logic [2:0]           retire_valid,
    input  logic [2:0][PR-1:0]   retire_told,
    output logic [2:0][PR-1:0]   fl_pr_out,
    output logic [1:0]           fl_avail,
    output logic                 fl_alloc_ok
);

    localparam int PW = FL_IDX + 1;
    localparam logic [PW-1:0] THREE = PW'(3);

    logic [PR-1:0]     entry_r [FL_SIZE];
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [PW-1:0]     arch_head_r;

    logic [PW-1:0]     count_s;
    logic [1:0]        req_cnt_s;
    logic [1:0]        ret_cnt_s;
    logic [1:0]        rd_off_s [3];
    logic [1:0]        wr_off_s [3];
    logic [FL_IDX-1:0] rd_idx_s [3];
    logic [FL_IDX-1:0] wr_idx_s [3];

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    // Slot offsets: older requesting slots take earlier entries, idle slots are skipped
    always_comb begin
        req_cnt_s   = pop3(dispatch_req);
        ret_cnt_s   = pop3(retire_valid);
        rd_off_s[2] = 2'd0;
        rd_off_s[1] = {1'b0, dispatch_req[2]};
        rd_off_s[0] = {1'b0, dispatch_req[2]} + {1'b0, dispatch_req[1]};
        wr_off_s[2] = 2'd0;
        wr_off_s[1] = {1'b0, retire_valid[2]};
        wr_off_s[0] = {1'b0, retire_valid[2]} + {1'b0, retire_valid[1]};
        for (int i = 0; i < 3; i++) begin
            rd_idx_s[i] = FL_IDX'(head_r + PW'(rd_off_s[i]));
            wr_idx_s[i] = FL_IDX'(tail_r + PW'(wr_off_s[i]));
        end
    end

    // Grant tags and availability purely from registered state
    always_comb begin
        count_s     = tail_r - head_r;
        fl_alloc_ok = (PW'(req_cnt_s) <= count_s);
        if (count_s >= THREE) begin
            fl_avail = 2'd3;
        end else begin
            fl_avail = count_s[1:0];
        end
        for (int i = 0; i < 3; i++) begin
            if (dispatch_req[i]) begin
                fl_pr_out[i] = entry_r[rd_idx_s[i]];
            end else begin
                fl_pr_out[i] = {PR{1'b0}};
            end
        end
    end

    // Pointer and entry update; retirement proceeds regardless of recovery
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                entry_r[i] <= PR'(ARCH_REGS + i);
            end
            head_r      <= {PW{1'b0}};
            arch_head_r <= {PW{1'b0}};
            tail_r      <= {1'b1, {FL_IDX{1'b0}}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (retire_valid[i]) begin
                    entry_r[wr_idx_s[i]] <= retire_told[i];
                end
            end
            tail_r      <= tail_r + PW'(ret_cnt_s);
            arch_head_r <= arch_head_r + PW'(ret_cnt_s);
            if (BPRecoverEN) begin
                head_r <= arch_head_r + PW'(ret_cnt_s);
            end else if (fl_alloc_ok) begin
                head_r <= head_r + PW'(req_cnt_s);
            end else begin
                head_r <= head_r;
            end
        end
    end

endmodule
